// File: rtl/bcd_down_timer_if.sv
// Control/status bundle between the keypad FSM (master) and the BCD
// countdown timer (slave). Digit i occupies data/digits[4i+3:4i].
interface bcd_down_timer_if #(
    parameter int NDIGITS = 4
);
    // control, driven by the keypad/control FSM
    logic [4*NDIGITS-1:0] data;
    logic                 loadn;
    logic                 start;
    logic                 stop;
    logic                 tick;
    logic                 add30;
    // status, driven by the timer
    logic [4*NDIGITS-1:0] digits;
    logic                 running;
    logic                 done;
    logic                 zero;
    logic                 tc;
    logic                 load_err;

    modport master (
        output data, loadn, start, stop, tick, add30,
        input  digits, running, done, zero, tc, load_err
    );

    modport slave (
        input  data, loadn, start, stop, tick, add30,
        output digits, running, done, zero, tc, load_err
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer (mm:ss in the default configuration).
// Each digit counts 9..0 or 5..0 (MOD6_MASK), digit 0 least significant.
// IDLE/RUN/DONE state machine; per-cycle priority load > stop > start >
// add30 > tick. Define BCD_TIMER_ADD30_EN to enable the +30 s quick-add;
// without it the add30 input is ignored and no adder is built.
module bcd_down_timer #(
    parameter int                 NDIGITS   = 4,
    parameter logic [NDIGITS-1:0] MOD6_MASK = 4'b0010
) (
    input  logic              clk,
    input  logic              clrn,
    bcd_down_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state;
    logic [NDIGITS-1:0][3:0]     cnt;
    logic                        running_q;
    logic                        done_q;
    logic                        tc_q;
    logic                        load_err_q;

    logic [NDIGITS-1:0][3:0]     clamp_val;   // data with each digit limited to its max
    logic [NDIGITS-1:0]          clamp_hit;   // digit i of data was out of range
    logic [NDIGITS-1:0][3:0]     dec_val;     // cnt - 1 in mixed BCD radix
    logic [NDIGITS-1:0]          borrow;      // digit i decrements on a tick
    logic [NDIGITS-1:0][3:0]     add_val;     // cnt + 30 s, saturated
    logic                        add_req;
    logic [4*NDIGITS-1:0]        cnt_flat;
    logic                        cnt_zero;
    logic                        cnt_one;

    assign cnt_flat = cnt;
    assign cnt_zero = (cnt_flat == '0);
    assign cnt_one  = (cnt_flat == (4*NDIGITS)'(1));

    // Least significant digit always decrements; higher ones only when
    // everything below them is already zero (borrow ripples upward).
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        localparam logic [3:0] MAX = MOD6_MASK[i] ? 4'd5 : 4'd9;

        // Out-of-range preset digits are clamped rather than rejected.
        assign clamp_hit[i] = (bus.data[4*i +: 4] > MAX);
        assign clamp_val[i] = clamp_hit[i] ? MAX : bus.data[4*i +: 4];

        // Decrement: a borrowing digit at 0 wraps to its own max.
        assign dec_val[i] = !borrow[i]        ? cnt[i] :
                            (cnt[i] == 4'd0)  ? MAX    :
                                                cnt[i] - 4'd1;

        if (i < NDIGITS - 1) begin : g_borrow
            assign borrow[i+1] = borrow[i] & (cnt[i] == 4'd0);
        end
    end

`ifdef BCD_TIMER_ADD30_EN
    // +30 s is +3 on the tens-of-seconds digit; carries ripple upward
    // digit by digit, each wrapping at its own modulus. A carry out of
    // the top digit means overflow, which saturates at all-max.
    logic [NDIGITS:0]            acarry;
    logic [NDIGITS-1:0][3:0]     add_sum;
    logic [NDIGITS-1:0][3:0]     max_all;

    assign acarry[0] = 1'b0;

    for (genvar i = 0; i < NDIGITS; i++) begin : g_add
        localparam logic [4:0] MAX5   = MOD6_MASK[i] ? 5'd5 : 5'd9;
        localparam logic [4:0] ADDEND = (i == 1) ? 5'd3 : 5'd0;
        logic [4:0] sum;
        logic [4:0] wrapped;

        assign sum         = {1'b0, cnt[i]} + ADDEND + {4'b0, acarry[i]};
        assign wrapped     = sum - (MAX5 + 5'd1);
        assign acarry[i+1] = (sum > MAX5);
        assign add_sum[i]  = acarry[i+1] ? wrapped[3:0] : sum[3:0];
        assign max_all[i]  = MAX5[3:0];
    end

    assign add_req = bus.add30;
    assign add_val = acarry[NDIGITS] ? max_all : add_sum;
`else
    logic unused_add30;
    assign unused_add30 = bus.add30;
    assign add_req      = 1'b0;
    assign add_val      = cnt;
`endif

    // Control FSM: one prioritised action per clock; status outputs are
    // registered alongside the state so they change with it.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            cnt        <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
            if (!bus.loadn) begin
                // load works from any state and always parks in IDLE
                cnt        <= clamp_val;
                state      <= IDLE;
                running_q  <= 1'b0;
                done_q     <= 1'b0;
                load_err_q <= |clamp_hit;
            end else if (bus.stop) begin
                // stop also masks a simultaneous start in IDLE
                if (state == RUN) begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                end
            end else if (bus.start && state == IDLE && !cnt_zero) begin
                // entering RUN consumes the cycle; a same-cycle tick is lost
                state     <= RUN;
                running_q <= 1'b1;
            end else if (add_req) begin
                // quick-add: from any state the timer ends up running
                cnt       <= add_val;
                state     <= RUN;
                running_q <= 1'b1;
                done_q    <= 1'b0;
            end else if (bus.tick && state == RUN) begin
                cnt <= dec_val;
                if (cnt_one) begin
                    state     <= DONE;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                    tc_q      <= 1'b1;
                end
            end
        end
    end

    assign bus.digits   = cnt_flat;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.zero     = cnt_zero;
    assign bus.tc       = tc_q;
    assign bus.load_err = load_err_q;

endmodule
